// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU operation codes and the controller-to-decoder aluop codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOP_NONE drives alucontrol to 000 in states that do not use the ALU.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop and the instruction funct field
// to the 3-bit ALU operation.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:  alucontrol = ALU_ADD;
            ALUOP_SUB:  alucontrol = ALU_SUB;
            ALUOP_NONE: alucontrol = ALU_AND;
            default: begin
                // Unrecognised funct codes fall back to add.
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller: state register plus state-decoded datapath
// controls; write enables are masked while reset is held.
module mips_mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] alucontrol,
    output logic [1:0] PCSrc,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_state;
    logic [1:0] w_aluop;
    logic       w_pc_en;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Under reset the datapath selects show their FETCH values.
    assign w_dec_state = rst ? S_FETCH : r_state;

    always_comb begin
        w_next     = S_FETCH;
        w_pc_en    = 1'b0;
        IorD       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        w_regwrite = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        w_aluop    = ALUOP_NONE;
        case (w_dec_state)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                w_aluop   = ALUOP_ADD;
                w_pc_en   = mem_ready;
                w_irwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                w_aluop = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_aluop = ALUOP_ADD;
                w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemToReg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                w_aluop = ALUOP_SUB;
                PCSrc   = 2'b01;
                w_pc_en = zero;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_aluop = ALUOP_ADD;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                w_pc_en = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (w_aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    assign pc_en    = w_pc_en    & ~rst;
    assign MemWrite = w_memwrite & ~rst;
    assign IRWrite  = w_irwrite  & ~rst;
    assign RegWrite = w_regwrite & ~rst;
    assign state    = r_state;

endmodule
